// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: result-source and load-type encodings plus the resolved retirement entry
package writeback_unit_pkg;
   localparam int WB_XLEN = 32;
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   typedef struct packed {
      logic               we;
      logic [4:0]         rd;
      logic [WB_XLEN-1:0] wd;
   } wb_entry_t;
endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: MEM-stage retire handshake, commit controls and register-file write port
interface writeback_unit_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             in_reg_write;
   logic [4:0]       in_rd;
   logic [1:0]       in_result_src;
   logic [XLEN-1:0]  in_alu_result;
   logic [XLEN-1:0]  in_read_data;
   logic [XLEN-1:0]  in_pc_plus4;
   logic [2:0]       in_funct3;
   logic             hold;
   logic             flush;
   logic [4:0]       wb_rd;
   logic             wb_we;
   logic [XLEN-1:0]  wb_wd;
   logic [CNT_W-1:0] retire_cnt;
   modport master (
      output in_valid, in_reg_write, in_rd, in_result_src, in_alu_result,
             in_read_data, in_pc_plus4, in_funct3, hold, flush,
      input  in_ready, wb_rd, wb_we, wb_wd, retire_cnt
   );
   modport slave (
      input  in_valid, in_reg_write, in_rd, in_result_src, in_alu_result,
             in_read_data, in_pc_plus4, in_funct3, hold, flush,
      output in_ready, wb_rd, wb_we, wb_wd, retire_cnt
   );
endinterface

// File: rtl/writeback_unit_load_extend.sv
// wb_load_extend: picks the addressed byte/half of a load word and sign- or zero-extends it
module wb_load_extend
   import writeback_unit_pkg::*;
(
   input  logic [2:0]         funct3,
   input  logic [1:0]         addr,
   input  logic [WB_XLEN-1:0] rdata,
   output logic [WB_XLEN-1:0] data
);
   logic [7:0]  b;
   logic [15:0] h;
   // lane select, then extension; unknown load types fall through to the full word
   always_comb begin
      b    = rdata[{addr, 3'b000} +: 8];
      h    = addr[1] ? rdata[31:16] : rdata[15:0];
      data = funct3 == F3_LB  ? {{24{b[7]}}, b}  :
             funct3 == F3_LH  ? {{16{h[15]}}, h} :
             funct3 == F3_LBU ? {24'b0, b}       :
             funct3 == F3_LHU ? {16'b0, h}       : rdata;
   end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: skid-buffered register-file write port; optional retire counter under WB_RETIRE_CNT_EN
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int XLEN  = WB_XLEN,
   parameter int DEPTH = 2,
   parameter int CNT_W = 32
) (
   input logic              clk,
   input logic              rst_n,
   writeback_unit_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
   wb_entry_t       mem_q [DEPTH];
   wb_entry_t       mem_d [DEPTH];
   wb_entry_t       out_q, out_d, in_e, src_e;
   logic [XLEN-1:0] ld_data;
   logic            empty, acc, commit, push, pop;

   wb_load_extend u_ext (
      .funct3 (bus.in_funct3),
      .addr   (bus.in_alu_result[1:0]),
      .rdata  (bus.in_read_data),
      .data   (ld_data)
   );

   assign bus.in_ready = (count_q < CW'(DEPTH)) && !bus.flush;

   // resolve the incoming entry, pick the commit source and advance the FIFO
   always_comb begin
      in_e.we = bus.in_reg_write && (bus.in_rd != 5'd0);
      in_e.rd = bus.in_rd;
      in_e.wd = bus.in_result_src == RES_MEM ? ld_data :
                bus.in_result_src == RES_PC4 ? bus.in_pc_plus4 : bus.in_alu_result;
      empty   = count_q == '0;
      acc     = bus.in_valid && bus.in_ready;
      commit  = !bus.hold && !bus.flush && (!empty || acc);
      pop     = commit && !empty;
      push    = acc && !(commit && empty);
      src_e   = empty ? in_e : mem_q[head_q];
      count_d = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
      head_d  = bus.flush ? '0 : head_q + AW'(pop);
      tail_d  = bus.flush ? '0 : tail_q + AW'(push);
      mem_d   = mem_q;
      if (push) mem_d[tail_q] = in_e;
      out_d   = commit ? src_e : {1'b0, out_q.rd, out_q.wd};
   end

   // FIFO state and registered write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         mem_q   <= '{default: '0};
         out_q   <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         mem_q   <= mem_d;
         out_q   <= out_d;
      end
   end

   assign bus.wb_we = out_q.we;
   assign bus.wb_rd = out_q.rd;
   assign bus.wb_wd = out_q.wd;

`ifdef WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = cnt_q + CNT_W'(commit);
   // every commit counts, including entries that do not write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
   assign bus.retire_cnt = cnt_q;
`else
   assign bus.retire_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed vector table plus hold, push/pop, flush and reset sequences
module tb_writeback_unit;
   typedef struct {
      logic        rw;
      logic [4:0]  rd;
      logic [1:0]  src;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] pc4;
      logic [2:0]  f3;
      logic        ewe;
      logic [31:0] ewd;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   int   exp_cnt = 0;
   vec_t v [14];

   writeback_unit_if #(.XLEN(32), .CNT_W(32)) bus ();
   writeback_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_rc();
`ifdef WB_RETIRE_CNT_EN
      return exp_cnt;
`else
      return 32'd0;
`endif
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic ent(input logic [4:0] rd, input logic [31:0] alu);
      bus.in_reg_write  = 1'b1;
      bus.in_rd         = rd;
      bus.in_result_src = 2'b00;
      bus.in_alu_result = alu;
      bus.in_funct3     = 3'b000;
   endtask

   task automatic chk_out(input string n, input logic [4:0] rd, input logic [31:0] wd);
      chk({n, "_we"}, 32'(bus.wb_we), 32'd1);
      chk({n, "_rd"}, 32'(bus.wb_rd), 32'(rd));
      chk({n, "_wd"}, bus.wb_wd, wd);
      chk({n, "_cnt"}, bus.retire_cnt, exp_rc());
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.hold = 1'b0; bus.flush = 1'b0;
      bus.in_read_data = '0; bus.in_pc_plus4 = '0;
      ent(5'd0, 32'd0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_we", 32'(bus.wb_we), 32'd0);
      chk("rst_rd", 32'(bus.wb_rd), 32'd0);
      chk("rst_wd", bus.wb_wd, 32'd0);
      chk("rst_cnt", bus.retire_cnt, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rst_ready", 32'(bus.in_ready), 32'd1);

      v[0]  = '{1'b1, 5'd5,  2'b00, 32'h1234_5678, 32'h0,         32'h0,   3'b000, 1'b1, 32'h1234_5678};
      v[1]  = '{1'b1, 5'd6,  2'b01, 32'h0000_0003, 32'h80FF_7F01, 32'h0,   3'b000, 1'b1, 32'hFFFF_FF80};
      v[2]  = '{1'b1, 5'd7,  2'b01, 32'h0000_0001, 32'h80FF_7F01, 32'h0,   3'b100, 1'b1, 32'h0000_007F};
      v[3]  = '{1'b1, 5'd8,  2'b01, 32'h0000_0002, 32'h80FF_7F01, 32'h0,   3'b001, 1'b1, 32'hFFFF_80FF};
      v[4]  = '{1'b1, 5'd9,  2'b01, 32'h0000_0000, 32'h80FF_7F01, 32'h0,   3'b101, 1'b1, 32'h0000_7F01};
      v[5]  = '{1'b1, 5'd10, 2'b01, 32'h0000_0003, 32'h80FF_7F01, 32'h0,   3'b001, 1'b1, 32'hFFFF_80FF};
      v[6]  = '{1'b1, 5'd11, 2'b01, 32'h0000_0001, 32'h80FF_7F01, 32'h0,   3'b010, 1'b1, 32'h80FF_7F01};
      v[7]  = '{1'b1, 5'd12, 2'b01, 32'h0000_0002, 32'h80FF_7F01, 32'h0,   3'b011, 1'b1, 32'h80FF_7F01};
      v[8]  = '{1'b1, 5'd0,  2'b00, 32'h0000_DEAD, 32'h0,         32'h0,   3'b000, 1'b0, 32'h0000_DEAD};
      v[9]  = '{1'b1, 5'd1,  2'b10, 32'h0000_0444, 32'h0,         32'h100, 3'b000, 1'b1, 32'h0000_0100};
      v[10] = '{1'b1, 5'd2,  2'b11, 32'h0000_CAFE, 32'h0,         32'h200, 3'b000, 1'b1, 32'h0000_CAFE};
      v[11] = '{1'b0, 5'd3,  2'b00, 32'h0000_0033, 32'h0,         32'h0,   3'b000, 1'b0, 32'h0000_0033};
      v[12] = '{1'b1, 5'd4,  2'b01, 32'h0000_0000, 32'h80FF_7F01, 32'h0,   3'b000, 1'b1, 32'h0000_0001};
      v[13] = '{1'b1, 5'd31, 2'b01, 32'h0000_0003, 32'h80FF_7F01, 32'h0,   3'b100, 1'b1, 32'h0000_0080};

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         bus.in_reg_write  = v[i].rw;
         bus.in_rd         = v[i].rd;
         bus.in_result_src = v[i].src;
         bus.in_alu_result = v[i].alu;
         bus.in_read_data  = v[i].rdata;
         bus.in_pc_plus4   = v[i].pc4;
         bus.in_funct3     = v[i].f3;
         bus.in_valid      = 1'b1;
         chk($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'd1);
         @(posedge clk);
         @(negedge clk);
         bus.in_valid = 1'b0;
         exp_cnt++;
         chk($sformatf("v%0d_we", i), 32'(bus.wb_we), 32'(v[i].ewe));
         chk($sformatf("v%0d_rd", i), 32'(bus.wb_rd), 32'(v[i].rd));
         chk($sformatf("v%0d_wd", i), bus.wb_wd, v[i].ewd);
         chk($sformatf("v%0d_cnt", i), bus.retire_cnt, exp_rc());
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_idle_we", i), 32'(bus.wb_we), 32'd0);
         chk($sformatf("v%0d_idle_wd", i), bus.wb_wd, v[i].ewd);
      end

      // hold with three back-to-back valids: two accepted, then full
      @(negedge clk);
      bus.hold = 1'b1; ent(5'd13, 32'hA1); bus.in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("hold_ready1", 32'(bus.in_ready), 32'd1);
      ent(5'd14, 32'hB2);
      @(posedge clk); @(negedge clk);
      chk("hold_full_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_we", 32'(bus.wb_we), 32'd0);
      ent(5'd15, 32'hC3);
      @(posedge clk); @(negedge clk);
      chk("hold_full_ready2", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b0; bus.hold = 1'b0;
      @(posedge clk); @(negedge clk);
      exp_cnt++;
      chk_out("rel_a", 5'd13, 32'hA1);
      chk("rel_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      exp_cnt++;
      chk_out("rel_b", 5'd14, 32'hB2);
      @(posedge clk); @(negedge clk);
      chk("rel_done_we", 32'(bus.wb_we), 32'd0);
      chk("rel_done_rd", 32'(bus.wb_rd), 32'd14);

      // simultaneous push and pop keeps order
      bus.hold = 1'b1; ent(5'd16, 32'hD4); bus.in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.hold = 1'b0; ent(5'd17, 32'hE5);
      @(posedge clk); @(negedge clk);
      exp_cnt++;
      chk_out("pp_d", 5'd16, 32'hD4);
      ent(5'd18, 32'hF6);
      @(posedge clk); @(negedge clk);
      exp_cnt++;
      chk_out("pp_e", 5'd17, 32'hE5);
      bus.in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      exp_cnt++;
      chk_out("pp_f", 5'd18, 32'hF6);
      @(posedge clk); @(negedge clk);
      chk("pp_idle_we", 32'(bus.wb_we), 32'd0);

      // flush while an entry sits in the output regs and one is buffered
      bus.hold = 1'b1; ent(5'd20, 32'h88); bus.in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      ent(5'd21, 32'h99);
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0; bus.hold = 1'b0;
      @(posedge clk); @(negedge clk);
      exp_cnt++;
      chk_out("fl_out", 5'd20, 32'h88);
      bus.flush = 1'b1; ent(5'd22, 32'hAA); bus.in_valid = 1'b1;
      #1 chk("fl_ready_low", 32'(bus.in_ready), 32'd0);
      @(posedge clk); @(negedge clk);
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      #1;
      chk("fl_we", 32'(bus.wb_we), 32'd0);
      chk("fl_rd_held", 32'(bus.wb_rd), 32'd20);
      chk("fl_ready", 32'(bus.in_ready), 32'd1);
      chk("fl_cnt", bus.retire_cnt, exp_rc());
      @(posedge clk); @(negedge clk);
      chk("fl_after_we", 32'(bus.wb_we), 32'd0);

      // flush with two buffered entries
      bus.hold = 1'b1; ent(5'd23, 32'h23); bus.in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      ent(5'd24, 32'h24);
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0; bus.hold = 1'b0; bus.flush = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.flush = 1'b0;
      #1 chk("fl2_ready", 32'(bus.in_ready), 32'd1);
      chk("fl2_we0", 32'(bus.wb_we), 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); @(negedge clk);
         chk($sformatf("fl2_we%0d", k + 1), 32'(bus.wb_we), 32'd0);
      end
      chk("fl2_cnt", bus.retire_cnt, exp_rc());

      // async reset between edges with one committed and one buffered
      bus.hold = 1'b1; ent(5'd25, 32'h55); bus.in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      ent(5'd26, 32'h66);
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0; bus.hold = 1'b0;
      @(posedge clk);
      #3;
      chk("ar_pre_we", 32'(bus.wb_we), 32'd1);
      rst_n = 1'b0;
      #1;
      exp_cnt = 0;
      chk("ar_we", 32'(bus.wb_we), 32'd0);
      chk("ar_rd", 32'(bus.wb_rd), 32'd0);
      chk("ar_wd", bus.wb_wd, 32'd0);
      chk("ar_cnt", bus.retire_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("ar_ready", 32'(bus.in_ready), 32'd1);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); @(negedge clk);
         chk($sformatf("ar_lost_we%0d", k), 32'(bus.wb_we), 32'd0);
      end
      ent(5'd27, 32'h11); bus.in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0;
      exp_cnt++;
      chk_out("ar_post", 5'd27, 32'h11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
